vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the text/timer display path. Divides the system clock to a
//  pixel rate and scans horizontal and vertical counters. Drives xOrd/yOrd/visible into the
//  text timer core. Emits hsync/vsync delayed to line up with that core's RGB pipeline.
//  Sits directly upstream of the text timer core; its sync outputs go straight to the VGA pins.
// PARAMETERS
//  CLK_DIV     2    system clocks per pixel (50 MHz -> 25 MHz); must be >= 1
//  H_VISIBLE   640  active pixels per line
//  H_FRONT     16   horizontal front porch, pixels
//  H_SYNC      96   hsync pulse width, pixels
//  H_BACK      48   horizontal back porch, pixels
//  V_VISIBLE   480  active lines per frame
//  V_FRONT     10   vertical front porch, lines
//  V_SYNC      2    vsync pulse width, lines
//  V_BACK      33   vertical back porch, lines
//  SYNC_ACT    0    active level of hsync/vsync (0 = active-low)
//  SYNC_DELAY  2    pixel ticks of delay on hsync/vsync (0..7), matches RGB pipeline latency
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  pixelTick   out  1   one-clk strobe, once per CLK_DIV clocks; marks each pixel advance
//  xOrd        out  10  horizontal count, 0..H_TOTAL-1
//  yOrd        out  10  vertical count, 0..V_TOTAL-1
//  visible     out  1   high when xOrd < H_VISIBLE and yOrd < V_VISIBLE
//  hsync       out  1   horizontal sync, delayed SYNC_DELAY ticks, level per SYNC_ACT
//  vsync       out  1   vertical sync, delayed SYNC_DELAY ticks, level per SYNC_ACT
//  lineStart   out  1   one-clk pulse on the edge where xOrd becomes 0
//  frameStart  out  1   one-clk pulse on the edge where xOrd and yOrd both become 0
// BEHAVIOUR
//  - Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL likewise (525).
//    Elaboration fails if either total exceeds 1024.
//  - Reset (async assert, sync release): divCnt=0, xOrd=0, yOrd=0, visible=0,
//    pixelTick=0, lineStart=0, frameStart=0. hsync/vsync and the whole delay line sit at
//    the inactive level, ~SYNC_ACT.
//  - Divider: divCnt counts 0..CLK_DIV-1 and wraps. pixelTick is registered and is high for
//    the single clk in which divCnt == CLK_DIV-1. With CLK_DIV=1 it stays high permanently.
//  - Counter advance, only on clk edges where pixelTick == 1:
//    - xOrd increments; at H_TOTAL-1 it wraps to 0 and yOrd increments.
//    - yOrd wraps from V_TOTAL-1 to 0 on the same edge that xOrd wraps.
//    - Outputs are registered and hold steady for CLK_DIV clks between ticks.
//  - First scan position after reset: the first tick moves the counters from reset (0,0) to
//    (1,0). Position (0,0) is reached again only after a full frame. visible updates on the
//    same edge as xOrd/yOrd.
//  - Raw syncs are computed from the next counter values:
//    - hs active for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//    - vs active for V_VISIBLE+V_FRONT <= y < +V_SYNC (490..491), for the full line width.
//  - Sync delay: raw syncs shift through a SYNC_DELAY-deep register chain that advances
//    only on ticks. SYNC_DELAY=0 means the syncs change on the same edge as xOrd/yOrd.
//  - lineStart and frameStart are registered on the tick edge that loads xOrd=0
//    (frameStart additionally requires yOrd=0). Each is exactly one clk wide regardless of
//    CLK_DIV.
//  - Reset mid-frame: everything returns to the reset state immediately. No partial sync
//    pulse survives; the outputs go inactive at once.
// STRUCTURE
//  - Shared package: timing constants H_*/V_* for 640x480@60, H_TOTAL/V_TOTAL, and a
//    function giving the sync active level. The text generator and the bench import the
//    same values.
//  - One natural sub-module: vga_sync_delay, a parameterised tick-enabled shift register
//    (WIDTH=2, DEPTH=SYNC_DELAY, reset value ~SYNC_ACT).
//  - Divider, counters and decode stay in the top module.
// TESTING
//  1. Reset held 10 clks, then released -> pixelTick high every 2nd clk.
//     The first tick gives xOrd=1, yOrd=0, visible=1. hsync=vsync=1 throughout reset.
//  2. Run one line (800 ticks) ->
//     - visible high for exactly 640 ticks.
//     - Raw hs low for ticks 656..751; hsync pin low 2 ticks later (658..753).
//     - lineStart pulses once, 1 clk wide.
//  3. Run one full frame (420000 ticks) ->
//     - vsync low for exactly 2 lines (1600 ticks), starting at line 490 + 2-tick delay.
//     - frameStart pulses once at (0,0); yOrd never exceeds 524.
//  4. Wrap check: at xOrd=799, yOrd=524, the next tick -> xOrd=0, yOrd=0.
//     lineStart and frameStart both high for that 1 clk.
//  5. Assert rst_n low at xOrd=700 (hsync active) -> hsync=1, xOrd=0 and pixelTick=0
//     immediately (before the next clk edge). After release, the sequence restarts as in 1.
//  6. Re-elaborate with CLK_DIV=1, SYNC_DELAY=0, SYNC_ACT=1 ->
//     - tick every clk; hsync high for x 656..751 on the same edge as the counters.
//     - Frame length 420000 clks.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants for the 640x480@60 text/timer display path.
// The timing generator, the text core and the bench all take their
// geometry from here so the three never drift apart.
package vga_timing_gen_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned MAX_TOTAL = 1 << COORD_W;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Pin levels of the two sync outputs, travelling together down the delay line.
  typedef struct packed {
    logic hs;
    logic vs;
  } sync_pair_t;

  // Pin level for a sync signal given its active polarity.
  function automatic logic sync_level(input logic act_level, input logic active);
    return active ? act_level : ~act_level;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the text timer core.
// The generator drives it (master); the text core and VGA pins consume it (slave).
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  logic               pixelTick;
  logic [COORD_W-1:0] xOrd;
  logic [COORD_W-1:0] yOrd;
  logic               visible;
  logic               hsync;
  logic               vsync;
  logic               lineStart;
  logic               frameStart;

  modport master (
    output pixelTick, xOrd, yOrd, visible, hsync, vsync, lineStart, frameStart
  );

  modport slave (
    input  pixelTick, xOrd, yOrd, visible, hsync, vsync, lineStart, frameStart
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Tick-enabled shift register that lines the sync outputs up with the
// RGB pipeline of the text core. DEPTH = 0 is a plain wire.
module vga_sync_delay #(
  parameter int unsigned       WIDTH   = 2,
  parameter int unsigned       DEPTH   = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_chain
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per enable; reset parks every stage at the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk to the pixel rate, scans x/y,
// decodes visible/sync and delays the syncs to match the RGB pipeline.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_VISIBLE  = vga_timing_gen_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT    = vga_timing_gen_pkg::H_FRONT,
  parameter int unsigned H_SYNC     = vga_timing_gen_pkg::H_SYNC,
  parameter int unsigned H_BACK     = vga_timing_gen_pkg::H_BACK,
  parameter int unsigned V_VISIBLE  = vga_timing_gen_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT    = vga_timing_gen_pkg::V_FRONT,
  parameter int unsigned V_SYNC     = vga_timing_gen_pkg::V_SYNC,
  parameter int unsigned V_BACK     = vga_timing_gen_pkg::V_BACK,
  parameter bit          SYNC_ACT   = 1'b0,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam sync_pair_t         SYNC_IDLE = '{hs: ~SYNC_ACT, vs: ~SYNC_ACT};

  if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (SYNC_DELAY > 7) begin : g_bad_sync_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..7");
  end

  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_next;
  logic               pixel_tick;
  logic [COORD_W-1:0] x_ord;
  logic [COORD_W-1:0] y_ord;
  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic [31:0]        xn;
  logic [31:0]        yn;
  logic               visible;
  logic               visible_next;
  logic               line_start;
  logic               frame_start;
  sync_pair_t         raw_sync;
  sync_pair_t         raw_sync_next;
  sync_pair_t         sync_out;

  // Divider wrap value; pixel_tick is registered off it so it lands on divCnt == CLK_DIV-1.
  always_comb begin
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // Scan position the counters move to on the next tick.
  always_comb begin
    x_next = x_ord;
    y_next = y_ord;
    if (x_ord == H_LAST) begin
      x_next = '0;
      y_next = (y_ord == V_LAST) ? '0 : y_ord + 1'b1;
    end else begin
      x_next = x_ord + 1'b1;
    end
  end

  assign xn = 32'(x_next);
  assign yn = 32'(y_next);

  // Decode visible area and raw sync pin levels from the upcoming position.
  always_comb begin
    visible_next     = (xn < H_VISIBLE) && (yn < V_VISIBLE);
    raw_sync_next.hs = sync_level(SYNC_ACT, (xn >= HS_START) && (xn < HS_END));
    raw_sync_next.vs = sync_level(SYNC_ACT, (yn >= VS_START) && (yn < VS_END));
  end

  // Divider, scan counters and registered decode; all state advances on ticks only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      pixel_tick  <= 1'b0;
      x_ord       <= '0;
      y_ord       <= '0;
      visible     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      raw_sync    <= SYNC_IDLE;
    end else begin
      div_cnt     <= div_next;
      pixel_tick  <= (div_next == DIV_LAST);
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_tick) begin
        x_ord       <= x_next;
        y_ord       <= y_next;
        visible     <= visible_next;
        raw_sync    <= raw_sync_next;
        line_start  <= (x_next == '0);
        frame_start <= (x_next == '0) && (y_next == '0);
      end
    end
  end

  vga_sync_delay #(
    .WIDTH   (2),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pixel_tick),
    .d     (raw_sync),
    .q     (sync_out)
  );

  assign vga.pixelTick  = pixel_tick;
  assign vga.xOrd       = x_ord;
  assign vga.yOrd       = y_ord;
  assign vga.visible    = visible;
  assign vga.hsync      = sync_out.hs;
  assign vga.vsync      = sync_out.vs;
  assign vga.lineStart  = line_start;
  assign vga.frameStart = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance, a
// CLK_DIV=1 / no-delay / active-high instance, and a miniature raster
// (16x9) that makes full-frame and wrap behaviour cheap to reach.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();
  vga_timing_gen_if ifc ();

  vga_timing_gen #(
    .CLK_DIV (2), .SYNC_DELAY (2), .SYNC_ACT (1'b0)
  ) dut_a (.clk (clk), .rst_n (rst_n), .vga (ifa));

  vga_timing_gen #(
    .CLK_DIV (1), .SYNC_DELAY (0), .SYNC_ACT (1'b1)
  ) dut_b (.clk (clk), .rst_n (rst_n), .vga (ifb));

  vga_timing_gen #(
    .CLK_DIV (2),
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
    .SYNC_DELAY (2), .SYNC_ACT (1'b0)
  ) dut_c (.clk (clk), .rst_n (rst_n), .vga (ifc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, vis, hs_n, hs_first, hs_last, ls, ls_x;
    int vn, v_first_x, v_first_y, cv, chs, ymax, fs, fs_x, fs_y, cls, flen;

    // Reset held 10 clks
    rst_n = 1'b0;
    repeat (10) step();
    check("rst_a_hsync", ifa.hsync, 1);
    check("rst_a_vsync", ifa.vsync, 1);
    check("rst_a_x", ifa.xOrd, 0);
    check("rst_a_tick", ifa.pixelTick, 0);
    check("rst_a_visible", ifa.visible, 0);
    check("rst_a_linestart", ifa.lineStart, 0);
    check("rst_b_hsync", ifb.hsync, 0);
    check("rst_c_vsync", ifc.vsync, 1);

    // Release: tick every 2nd clk, first tick lands on (1,0)
    rst_n = 1'b1;
    step();
    check("e1_a_tick", ifa.pixelTick, 1);
    check("e1_a_x", ifa.xOrd, 0);
    step();
    check("e2_a_x", ifa.xOrd, 1);
    check("e2_a_y", ifa.yOrd, 0);
    check("e2_a_visible", ifa.visible, 1);
    check("e2_a_tick", ifa.pixelTick, 0);
    check("e2_a_hsync", ifa.hsync, 1);
    step();
    check("e3_a_tick", ifa.pixelTick, 1);

    // One full line on the default instance
    ticks = 0; vis = 0; hs_n = 0; hs_first = -1; hs_last = -1; ls = 0; ls_x = -1;
    for (int i = 0; i < 1600; i++) begin
      if (ifa.pixelTick) begin
        ticks++;
        if (ifa.visible) vis++;
        if (!ifa.hsync) begin
          hs_n++;
          if (hs_first < 0) hs_first = int'(ifa.xOrd);
          hs_last = int'(ifa.xOrd);
        end
      end
      if (ifa.lineStart) begin
        ls++;
        ls_x = int'(ifa.xOrd);
      end
      step();
    end
    check("line_ticks", ticks, 800);
    check("line_visible", vis, 640);
    check("line_hs_count", hs_n, 96);
    check("line_hs_first", hs_first, 658);
    check("line_hs_last", hs_last, 753);
    check("line_linestart", ls, 1);
    check("line_linestart_x", ls_x, 0);
    check("line_end_x", ifa.xOrd, 1);
    check("line_end_y", ifa.yOrd, 1);

    // Reset mid-line while hsync is active
    repeat (1398) step();
    check("mid_x", ifa.xOrd, 700);
    check("mid_hsync", ifa.hsync, 0);
    check("mid_tick", ifa.pixelTick, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_hsync", ifa.hsync, 1);
    check("async_x", ifa.xOrd, 0);
    check("async_tick", ifa.pixelTick, 0);
    check("async_visible", ifa.visible, 0);
    repeat (10) step();
    rst_n = 1'b1;
    step();
    check("re1_a_tick", ifa.pixelTick, 1);
    check("re1_a_x", ifa.xOrd, 0);
    check("re1_b_tick", ifb.pixelTick, 1);
    check("re1_b_x", ifb.xOrd, 0);
    step();
    check("re2_a_x", ifa.xOrd, 1);
    check("re2_a_visible", ifa.visible, 1);
    check("re2_a_tick", ifa.pixelTick, 0);
    check("re2_b_x", ifb.xOrd, 1);
    check("re2_b_hsync", ifb.hsync, 0);

    // CLK_DIV=1, no delay, active-high sync: one line
    ticks = 0; hs_n = 0; hs_first = -1; hs_last = -1; ls = 0;
    for (int i = 0; i < 800; i++) begin
      if (ifb.pixelTick) ticks++;
      if (ifb.hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(ifb.xOrd);
        hs_last = int'(ifb.xOrd);
      end
      if (ifb.lineStart) ls++;
      step();
    end
    check("b_ticks", ticks, 800);
    check("b_hs_count", hs_n, 96);
    check("b_hs_first", hs_first, 656);
    check("b_hs_last", hs_last, 751);
    check("b_linestart", ls, 1);
    check("b_end_x", ifb.xOrd, 1);
    check("b_end_y", ifb.yOrd, 1);

    // Miniature raster: full frame, vsync window, wrap
    rst_n = 1'b0;
    repeat (10) step();
    rst_n = 1'b1;
    step();
    check("c_e1_tick", ifc.pixelTick, 1);
    step();
    check("c_e2_x", ifc.xOrd, 1);
    vn = 0; v_first_x = -1; v_first_y = -1; cv = 0; chs = 0; ymax = 0;
    fs = 0; fs_x = -1; fs_y = -1; cls = 0;
    for (int i = 0; i < 288; i++) begin
      if (ifc.pixelTick) begin
        if (!ifc.vsync) begin
          vn++;
          if (v_first_x < 0) begin
            v_first_x = int'(ifc.xOrd);
            v_first_y = int'(ifc.yOrd);
          end
        end
        if (ifc.visible) cv++;
        if (!ifc.hsync) chs++;
        if (int'(ifc.yOrd) > ymax) ymax = int'(ifc.yOrd);
      end
      if (ifc.frameStart) begin
        fs++;
        fs_x = int'(ifc.xOrd);
        fs_y = int'(ifc.yOrd);
      end
      if (ifc.lineStart) cls++;
      if (i == 285) begin
        check("wrap_pre_x", ifc.xOrd, 15);
        check("wrap_pre_y", ifc.yOrd, 8);
      end
      if (i == 286) begin
        check("wrap_x", ifc.xOrd, 0);
        check("wrap_y", ifc.yOrd, 0);
        check("wrap_linestart", ifc.lineStart, 1);
        check("wrap_framestart", ifc.frameStart, 1);
      end
      step();
    end
    check("c_vs_count", vn, 32);
    check("c_vs_first_y", v_first_y, 5);
    check("c_vs_first_x", v_first_x, 2);
    check("c_visible", cv, 32);
    check("c_hs_count", chs, 27);
    check("c_ymax", ymax, 8);
    check("c_framestart", fs, 1);
    check("c_framestart_x", fs_x, 0);
    check("c_framestart_y", fs_y, 0);
    check("c_linestart", cls, 9);

    flen = 2;
    while (!ifc.frameStart && flen < 400) begin
      step();
      flen++;
    end
    check("c_frame_len", flen, 288);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
